// File: rtl/fixed_point_accumulator_if.sv
// Handshake bundle between the multiplier stage, the burst accumulator and
// its downstream consumer.
//   in_valid/in_ready/in_data : product sample stream (unsigned Q(DATA_W-2).2)
//   clear                     : synchronous burst abort
//   out_valid/out_ready       : burst-sum handshake
//   out_sum/out_ovf           : unsigned Q(ACC_W-2).2 burst sum and overflow flag
// master = producer/consumer side that drives the sample stream and out_ready;
// slave  = the accumulator itself.
interface fixed_point_accumulator_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/fixed_point_accumulator.sv
// Burst accumulator: sums LEN unsigned Q.2 product samples and presents the
// sum plus an overflow flag on a second valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (discards any pending sum)
//   bus  - fixed_point_accumulator_if.slave (sample in, clear, sum out)
// Parameters: DATA_W (input width), ACC_W (>= DATA_W, sum width),
//   LEN (1..255 samples per burst).
// Build option: define ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on
//   overflow; otherwise the sum wraps modulo 2^ACC_W. out_ovf is set in both.
module fixed_point_accumulator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 10,
    parameter int unsigned LEN    = 4
) (
    input logic                         clk,
    input logic                         rst,
    fixed_point_accumulator_if.slave    bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int unsigned      CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_store;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;
    logic [ACC_W-1:0]  out_sum_r;
    logic              out_ovf_r;
    logic [ACC_W:0]    sum_next;
    logic              carry;
    logic              in_ready_i;
    logic              in_xfer;
    logic              last;

    // Add at ACC_W+1 bits so the top bit is the carry out of the accumulator.
    always_comb begin
        sum_next = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.in_data};
        carry    = sum_next[ACC_W];
`ifdef ACC_SATURATE_EN
        // Once clamped, acc is all ones so any further non-zero add carries
        // again and re-clamps; adding zero leaves it at max.
        acc_store = carry ? '1 : sum_next[ACC_W-1:0];
`else
        acc_store = sum_next[ACC_W-1:0];
`endif
    end

    always_comb begin
        in_xfer = bus.in_valid && in_ready_i;
        last    = (cnt == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // Next-state logic; clear overrides both handshakes.
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (in_xfer && last) state_next = HOLD;
                HOLD:    if (bus.out_ready)   state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready_i    = (state == ACCUM);
        bus.out_valid = (state == HOLD);
    end

    assign bus.in_ready = in_ready_i;
    assign bus.out_sum  = out_sum_r;
    assign bus.out_ovf  = out_ovf_r;

    // Datapath. A sample presented together with clear is dropped; out_sum
    // and out_ovf survive clear and only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_sum_r <= '0;
            out_ovf_r <= 1'b0;
        end else if (bus.clear) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (in_xfer) begin
            if (last) begin
                out_sum_r <= acc_store;
                out_ovf_r <= ovf_acc | carry;
                acc       <= '0;
                cnt       <= '0;
                ovf_acc   <= 1'b0;
            end else begin
                acc     <= acc_store;
                cnt     <= cnt + 1'b1;
                ovf_acc <= ovf_acc | carry;
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator. Three instances share one stimulus:
//   d0: defaults (LEN=4, ACC_W=10); d9: ACC_W=9, LEN=4; d1: LEN=1.
// A burst-level model per instance predicts every output on every cycle,
// and directed literal checks pin the model to hand-computed values.
// Compile with +define+ACC_SATURATE_EN to match the saturating build.
module tb_fixed_point_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fixed_point_accumulator_if #(.DATA_W(8), .ACC_W(10)) if0 ();
    fixed_point_accumulator_if #(.DATA_W(8), .ACC_W(9))  if9 ();
    fixed_point_accumulator_if #(.DATA_W(8), .ACC_W(10)) if1 ();

    assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
    assign if0.clear = clear;        assign if0.out_ready = out_ready;
    assign if9.in_valid = in_valid;  assign if9.in_data = in_data;
    assign if9.clear = clear;        assign if9.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
    assign if1.clear = clear;        assign if1.out_ready = out_ready;

    fixed_point_accumulator #(.DATA_W(8), .ACC_W(10), .LEN(4)) d0 (.clk(clk), .rst(rst), .bus(if0));
    fixed_point_accumulator #(.DATA_W(8), .ACC_W(9),  .LEN(4)) d9 (.clk(clk), .rst(rst), .bus(if9));
    fixed_point_accumulator #(.DATA_W(8), .ACC_W(10), .LEN(1)) d1 (.clk(clk), .rst(rst), .bus(if1));

    logic       a_ir[3];
    logic       a_ov[3];
    logic       a_of[3];
    logic [9:0] a_os[3];
    assign a_ir[0] = if0.in_ready;  assign a_ov[0] = if0.out_valid;
    assign a_of[0] = if0.out_ovf;   assign a_os[0] = if0.out_sum;
    assign a_ir[1] = if9.in_ready;  assign a_ov[1] = if9.out_valid;
    assign a_of[1] = if9.out_ovf;   assign a_os[1] = {1'b0, if9.out_sum};
    assign a_ir[2] = if1.in_ready;  assign a_ov[2] = if1.out_valid;
    assign a_of[2] = if1.out_ovf;   assign a_os[2] = if1.out_sum;

    // ---------------- burst-level reference model ----------------
    int unsigned m_len[3] = '{4, 4, 1};
    int unsigned m_aw[3]  = '{10, 9, 10};
    bit          m_hold[3];
    int unsigned m_cnt[3];
    longint      m_total[3];
    longint      m_sum[3];
    bit          m_ovf[3];
    bit          started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            longint maxv;
            maxv = (longint'(1) << m_aw[k]) - 1;
            if (rst) begin
                m_hold[k] = 0; m_cnt[k] = 0; m_total[k] = 0;
                m_sum[k] = 0;  m_ovf[k] = 0;
            end else if (clear) begin
                m_hold[k] = 0; m_cnt[k] = 0; m_total[k] = 0;
            end else if (!m_hold[k] && in_valid) begin
                m_total[k] += longint'(in_data);
                m_cnt[k]++;
                if (m_cnt[k] == m_len[k]) begin
                    m_ovf[k] = (m_total[k] > maxv);
`ifdef ACC_SATURATE_EN
                    m_sum[k] = m_ovf[k] ? maxv : m_total[k];
`else
                    m_sum[k] = m_total[k] & maxv;
`endif
                    m_hold[k] = 1; m_cnt[k] = 0; m_total[k] = 0;
                end
            end else if (m_hold[k] && out_ready) begin
                m_hold[k] = 0;
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d.in_ready", k),  longint'(a_ir[k]), longint'(!m_hold[k]));
                chk($sformatf("d%0d.out_valid", k), longint'(a_ov[k]), longint'(m_hold[k]));
                chk($sformatf("d%0d.out_sum", k),   longint'(a_os[k]), m_sum[k]);
                chk($sformatf("d%0d.out_ovf", k),   longint'(a_of[k]), longint'(m_ovf[k]));
            end
        end
    end

    // Present inputs for one edge; returns 1 time unit after that edge.
    task automatic drive(input bit v, input logic [7:0] d, input bit c,
                         input bit o, input bit r = 1'b0);
        in_valid = v; in_data = d; clear = c; out_ready = o; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 8'h00, 0, 1, 1);
        drive(0, 8'h00, 0, 1, 1);
        chk("reset.in_ready",  longint'(if0.in_ready), 1);
        chk("reset.out_valid", longint'(if0.out_valid), 0);
        chk("reset.out_sum",   longint'(if0.out_sum), 0);

        // Basic burst.
        drive(1, 8'h0A, 0, 1); drive(1, 8'h04, 0, 1);
        drive(1, 8'h06, 0, 1); drive(1, 8'h02, 0, 1);
        chk("t1.out_valid", longint'(if0.out_valid), 1);
        chk("t1.out_sum",   longint'(if0.out_sum), 'h016);
        chk("t1.out_ovf",   longint'(if0.out_ovf), 0);
        chk("t1.in_ready",  longint'(if0.in_ready), 0);
        drive(0, 8'h00, 0, 1);
        chk("t1.in_ready_back", longint'(if0.in_ready), 1);

        // Overflow on the narrow accumulator.
        repeat (4) drive(1, 8'hFF, 0, 1);
`ifdef ACC_SATURATE_EN
        chk("t2.d9_sum", longint'(if9.out_sum), 'h1FF);
`else
        chk("t2.d9_sum", longint'(if9.out_sum), 'h1FC);
`endif
        chk("t2.d9_ovf", longint'(if9.out_ovf), 1);
        chk("t2.d0_sum", longint'(if0.out_sum), 'h3FC);
        drive(0, 8'h00, 0, 1);
        repeat (4) drive(1, 8'h01, 0, 1);
        chk("t2.d9_sum_next", longint'(if9.out_sum), 'h004);
        chk("t2.d9_ovf_next", longint'(if9.out_ovf), 0);
        drive(0, 8'h00, 0, 1);

        // Backpressure with a sample held during HOLD.
        repeat (4) drive(1, 8'h10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t3.out_valid", longint'(if0.out_valid), 1);
            chk("t3.out_sum",   longint'(if0.out_sum), 'h040);
            chk("t3.in_ready",  longint'(if0.in_ready), 0);
            drive(1, 8'h20, 0, 0);
        end
        drive(1, 8'h20, 0, 1);
        chk("t3.released", longint'(if0.out_valid), 0);
        repeat (4) drive(1, 8'h20, 0, 1);
        chk("t3.next_sum", longint'(if0.out_sum), 'h080);
        drive(0, 8'h00, 0, 1);

        // Clear drops the in-flight burst and the sample on the clear cycle.
        drive(1, 8'h08, 0, 1); drive(1, 8'h08, 0, 1);
        drive(1, 8'h08, 1, 1);
        repeat (4) drive(1, 8'h03, 0, 1);
        chk("t4.sum",   longint'(if0.out_sum), 'h00C);
        chk("t4.valid", longint'(if0.out_valid), 1);
        drive(0, 8'h00, 0, 1);

        // Reset while holding a sum.
        drive(1, 8'h0A, 0, 1); drive(1, 8'h04, 0, 1);
        drive(1, 8'h06, 0, 1); drive(1, 8'h02, 0, 0);
        chk("t5.hold_sum", longint'(if0.out_sum), 'h016);
        drive(0, 8'h00, 0, 0, 1);
        chk("t5.out_valid", longint'(if0.out_valid), 0);
        chk("t5.out_sum",   longint'(if0.out_sum), 0);
        chk("t5.in_ready",  longint'(if0.in_ready), 1);
        repeat (4) drive(1, 8'h01, 0, 1);
        chk("t5.new_sum", longint'(if0.out_sum), 'h004);
        drive(0, 8'h00, 0, 1);

        // LEN=1 alternation.
        drive(1, 8'h05, 0, 1);
        chk("t6.sum5",   longint'(if1.out_sum), 'h005);
        chk("t6.valid5", longint'(if1.out_valid), 1);
        chk("t6.rdy5",   longint'(if1.in_ready), 0);
        drive(1, 8'h07, 0, 1);
        chk("t6.gap_valid", longint'(if1.out_valid), 0);
        chk("t6.gap_rdy",   longint'(if1.in_ready), 1);
        drive(1, 8'h07, 0, 1);
        chk("t6.sum7",   longint'(if1.out_sum), 'h007);
        chk("t6.valid7", longint'(if1.out_valid), 1);

        // Randomised traffic checked by the per-cycle model comparison.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 199) == 0);
        end
        drive(0, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fixed_point_accumulator.md
Name: fixed_point_accumulator

Overview:
- Downstream consumer of the unsigned fixed-point multiplier stage.
- Takes its 8-bit unsigned products (Q6.2, already realigned by >>2) over a valid/ready handshake and sums a burst of LEN samples.
- Presents the burst sum with an overflow flag on a second valid/ready handshake.
- Forms the accumulate half of the team's fixed-point MAC datapath. The fractional point is unchanged, so the output is Q(ACC_W-2).2.

Parameters:
- DATA_W, 8, width of unsigned product input (Q(DATA_W-2).2).
- ACC_W, 10, accumulator/output width; must be >= DATA_W. The default DATA_W+log2(LEN) never overflows.
- LEN, 4, samples per burst; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  product sample valid
- in_ready  output  1  accumulator accepts sample
- in_data  input  DATA_W  unsigned Q.2 product
- clear  input  1  synchronous burst abort
- out_valid  output  1  burst sum valid
- out_ready  input  1  downstream accepts sum
- out_sum  output  ACC_W  unsigned Q.2 burst sum
- out_ovf  output  1  overflow occurred in this burst

Behaviour:
- One clock domain. All state is registered on the rising edge of clk.
- Reset (rst=1 at an edge): state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0. This holds mid-burst and mid-HOLD: any pending sum is discarded.
- in_ready = (state==ACCUM), combinational from state. out_valid = (state==HOLD), registered.
- Handshakes: in_valid && in_ready transfers a sample; out_valid && out_ready transfers the sum.
  - in_valid must not depend on in_ready; likewise out_ready must not depend on out_valid.
  - Data is sampled only on transfer.
- ACCUM state:
  - On input transfer: sum_next = acc + zero-extended in_data, computed at ACC_W+1 bits. The carry bit is the overflow of that add.
  - When cnt < LEN-1: acc <= sum_next (overflow rule below), cnt++, ovf_acc |= carry.
  - When cnt == LEN-1: out_sum <= sum_next (overflow rule), out_ovf <= ovf_acc|carry, state <= HOLD, acc<=0, cnt<=0, ovf_acc<=0.
- HOLD state:
  - out_sum and out_ovf are stable; in_ready=0.
  - On out_ready, the next state is ACCUM. out_sum/out_ovf keep their values, but are meaningful only while out_valid=1.
- Latency: out_valid rises on the cycle after the edge that accepted the LEN-th sample. This gives a minimum of 1 bubble cycle between bursts.
- Throughput: at best LEN+1 cycles per burst with out_ready tied high.
- LEN=1: every accepted sample goes directly to HOLD.
- clear (rst has priority over clear; clear has priority over both handshakes):
  - Any state: acc=0, cnt=0, ovf_acc=0, state=ACCUM, out_valid=0.
  - A sample presented in the same cycle is dropped, not accepted. in_ready is still 1 that cycle when in ACCUM, so the upstream must also treat clear as a flush.
- Samples with in_valid=1 during HOLD are ignored; the upstream holds them until in_ready.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: on carry, the stored value (acc or out_sum) clamps to 2^ACC_W-1 and stays clamped for the rest of the burst. out_ovf=1.
- Undefined: wrap modulo 2^ACC_W. out_ovf=1 if any add in the burst carried.
- Handshake timing is identical in both builds.

Test Plan:
- Defaults (LEN=4, ACC_W=10), out_ready=1, samples 0x0A,0x04,0x06,0x02 back-to-back -> one cycle after the 4th transfer, out_valid=1, out_sum=0x016 (5.50), out_ovf=0. in_ready=0 for exactly that cycle.
- ACC_W=9, LEN=4, four samples 0xFF:
  - Wrap build -> out_sum=0x1FC, out_ovf=1.
  - ACC_SATURATE_EN build -> out_sum=0x1FF, out_ovf=1.
  - Next burst 0x01×4 -> out_sum=0x004, out_ovf=0 in both builds.
- Backpressure: burst 0x10×4 with out_ready=0 for 3 cycles after out_valid -> out_valid, out_sum=0x040 stable and in_ready=0 for those cycles. An in_valid=1 sample held during HOLD is accepted on the first cycle after the out transfer and counts toward the next burst.
- clear after 2 accepted samples (0x08,0x08), with in_valid=1 data 0x08 on the clear cycle -> that sample is dropped. Next four samples 0x03 -> out_sum=0x00C.
- rst asserted for 1 cycle while in HOLD with out_sum=0x016 -> next cycle out_valid=0, out_sum=0, in_ready=1. A new burst of 0x01×4 yields 0x004.
- LEN=1: samples 0x05 then 0x07 with out_ready=1 -> out_sum 0x005 then 0x007, each valid 1 cycle after its transfer, alternating in_ready/out_valid.
